// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute for lw, sw, R, I-ALU and beq.
// Define MULTICYCLE_CTRL_TRAP_EN to lock into TRAP on an unsupported opcode instead of treating it as a NOP.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_q;
  logic       op_known;
  logic [2:0] alu_dec;

  assign op_known = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
                    (op == OP_ITYPE) || (op == OP_BRANCH);
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:    if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state_q <= S_MEMADR;
            OP_RTYPE:          state_q <= S_EXECR;
            OP_ITYPE:          state_q <= S_EXECI;
            OP_BRANCH:         state_q <= S_BEQ;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            default:           state_q <= S_TRAP;
`else
            default:           state_q <= S_FETCH;
`endif
          endcase
        end
        S_MEMADR:   state_q <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWB:    state_q <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state_q <= S_FETCH;
        S_EXECR:    state_q <= S_ALUWB;
        S_EXECI:    state_q <= S_ALUWB;
        S_ALUWB:    state_q <= S_FETCH;
        S_BEQ:      state_q <= S_FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        S_TRAP:     state_q <= S_TRAP;
`endif
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // funct7b5 selects sub only for register-register ops; addi ignores it.
  always_comb begin
    case (funct3)
      3'b000:  alu_dec = (state_q == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      default:   ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
`ifndef MULTICYCLE_CTRL_TRAP_EN
        illegal = !op_known;
`endif
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = Zero;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      S_TRAP:   illegal = 1'b1;
`endif
      default: ;
    endcase
    // Reset masks every write path so an abandoned instruction leaves no trace.
    if (rst) begin
      mem_req  = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = op_known;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle.
// Also covers the MULTICYCLE_CTRL_TRAP_EN build when that macro is defined.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mw_cnt = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Drive mem_ready for this cycle, let outputs settle, then check the state.
  task automatic at(input string tag, input logic r, input int st);
    mem_ready = r;
    #1;
    check({tag, "_state"}, state_dbg, st);
    mw_cnt += int'(MemWrite);
  endtask

  task automatic load_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    cyc = 0; mw_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_state", state_dbg, 0);
    check("rst_en", {mem_req, PCWrite, IRWrite, MemWrite, RegWrite, illegal}, 6'b0);
    rst = 1'b0;

    // lw, zero wait states: 0,1,2,3,4 then FETCH
    load_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    at("lw_f", 1'b1, 0);
    check("lw_f_en", {mem_req, IRWrite, PCWrite, AdrSrc}, 4'b1110);
    check("lw_f_mux", {ALUSrcA, ALUSrcB, ResultSrc, ALUControl}, {2'b00, 2'b10, 2'b10, 3'b000});
    tick();
    at("lw_d", 1'b1, 1);
    check("lw_d_mux", {ALUSrcA, ALUSrcB, RegWrite}, {2'b01, 2'b01, 1'b0});
    tick();
    at("lw_a", 1'b1, 2);
    check("lw_a_mux", {ALUSrcA, ALUSrcB, mem_req}, {2'b10, 2'b01, 1'b0});
    tick();
    at("lw_r", 1'b1, 3);
    check("lw_r_en", {mem_req, AdrSrc, RegWrite}, 3'b110);
    tick();
    at("lw_wb", 1'b1, 4);
    check("lw_wb_en", {RegWrite, ResultSrc}, {1'b1, 2'b01});
    tick();
    at("lw_end", 1'b1, 0);
    check("lw_cycles", cyc, 5);

    // sw with two stall cycles in MEMWRITE
    load_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    at("sw_f", 1'b1, 0); tick();
    at("sw_d", 1'b1, 1);
    check("sw_imm", ImmSrc, 2'b01);
    tick();
    at("sw_a", 1'b1, 2); tick();
    at("sw_w0", 1'b0, 5);
    check("sw_w0_en", {mem_req, AdrSrc, MemWrite}, 3'b110);
    tick();
    at("sw_w1", 1'b0, 5); tick();
    at("sw_w2", 1'b1, 5);
    check("sw_w2_mw", MemWrite, 1'b1);
    tick();
    at("sw_end", 1'b1, 0);
    check("sw_cycles", cyc, 6);
    check("sw_mw_pulses", mw_cnt, 1);

    // R-type sub
    load_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    at("sub_f", 1'b1, 0); tick();
    at("sub_d", 1'b1, 1); tick();
    at("sub_x", 1'b1, 6);
    check("sub_alu", {ALUControl, ALUSrcA, ALUSrcB}, {3'b001, 2'b10, 2'b00});
    tick();
    at("sub_wb", 1'b1, 8);
    check("sub_wb_en", {RegWrite, ResultSrc}, {1'b1, 2'b00});
    tick();
    at("sub_end", 1'b1, 0);
    check("sub_cycles", cyc, 4);

    // addi with funct7b5 set must still add
    load_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
    at("addi_f", 1'b1, 0); tick();
    at("addi_d", 1'b1, 1); tick();
    at("addi_x", 1'b1, 7);
    check("addi_alu", {ALUControl, ALUSrcB}, {3'b000, 2'b01});
    tick();
    at("addi_wb", 1'b1, 8); tick();
    at("addi_end", 1'b1, 0);
    check("addi_cycles", cyc, 4);

    // R-type slt and I-type ori/andi decode
    load_instr(7'b0110011, 3'b010, 1'b0, 1'b0);
    at("slt_f", 1'b1, 0); tick();
    at("slt_d", 1'b1, 1); tick();
    at("slt_x", 1'b1, 6);
    check("slt_alu", ALUControl, 3'b101);
    tick(); at("slt_wb", 1'b1, 8); tick();
    load_instr(7'b0010011, 3'b110, 1'b0, 1'b0);
    at("ori_f", 1'b1, 0); tick();
    at("ori_d", 1'b1, 1); tick();
    at("ori_x", 1'b1, 7);
    check("ori_alu", ALUControl, 3'b011);
    tick(); at("ori_wb", 1'b1, 8); tick();
    load_instr(7'b0010011, 3'b111, 1'b0, 1'b0);
    at("andi_f", 1'b1, 0); tick();
    at("andi_d", 1'b1, 1); tick();
    at("andi_x", 1'b1, 7);
    check("andi_alu", ALUControl, 3'b010);
    tick(); at("andi_wb", 1'b1, 8); tick();

    // beq taken
    load_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
    at("beq1_f", 1'b1, 0); tick();
    at("beq1_d", 1'b1, 1);
    check("beq1_imm", ImmSrc, 2'b10);
    tick();
    at("beq1_b", 1'b1, 9);
    check("beq1_pcw", {PCWrite, ALUControl, ALUSrcA, ALUSrcB}, {1'b1, 3'b001, 2'b10, 2'b00});
    tick();
    at("beq1_end", 1'b1, 0);
    check("beq1_cycles", cyc, 3);

    // beq not taken, with a one-cycle fetch stall first
    load_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
    at("beq0_fs", 1'b0, 0);
    check("beq0_fs_en", {mem_req, IRWrite, PCWrite}, 3'b100);
    tick();
    at("beq0_f", 1'b1, 0); tick();
    at("beq0_d", 1'b1, 1); tick();
    at("beq0_b", 1'b1, 9);
    check("beq0_pcw", PCWrite, 1'b0);
    tick();
    at("beq0_end", 1'b1, 0);
    check("beq0_cycles", cyc, 4);

    // reset during a stalled MEMREAD
    load_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    at("rlw_f", 1'b1, 0); tick();
    at("rlw_d", 1'b1, 1); tick();
    at("rlw_a", 1'b1, 2); tick();
    at("rlw_r", 1'b0, 3);
    rst = 1'b1;
    #1;
    check("rlw_rst_en", {mem_req, RegWrite, PCWrite, IRWrite, MemWrite}, 5'b0);
    tick();
    #1;
    check("rlw_rst_state", state_dbg, 0);
    check("rlw_rst_en2", {mem_req, RegWrite, PCWrite, IRWrite}, 4'b0);
    rst = 1'b0;

    // unsupported opcode
    load_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
    at("ill_f", 1'b1, 0); tick();
`ifdef MULTICYCLE_CTRL_TRAP_EN
    at("ill_d", 1'b1, 1); tick();
    for (int i = 0; i < 10; i++) begin
      at("ill_trap", 1'b1, 10);
      check("ill_trap_flag", {illegal, mem_req, PCWrite, IRWrite, MemWrite, RegWrite}, 6'b100000);
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    at("ill_after_rst", 1'b1, 0);
`else
    at("ill_d", 1'b1, 1);
    check("ill_d_flag", {illegal, PCWrite, IRWrite, MemWrite, RegWrite}, 5'b10000);
    tick();
    at("ill_back", 1'b1, 0);
    check("ill_back_flag", illegal, 1'b0);
    check("ill_cycles", cyc, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM that sequences the RV32I multi-cycle datapath (PC, instruction register, shared memory port, register file, ALU and the immediate extender) one instruction at a time. It decodes the latched opcode, drives the extender's `ImmSrc`, selects ALU operands and result source, and stalls on a memory-ready handshake. It sits beside the datapath in the CPU top and is the only source of write enables for PC, IR, memory and register file.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  7  instruction opcode, from IR[6:0].
- `funct3`  in  3  from IR[14:12].
- `funct7b5`  in  1  from IR[30].
- `Zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completed the current access this cycle.
- `mem_req`  out  1  memory access request.
- `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite`  out  1 each  write enables.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB`  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUControl`  out  3  operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B.
- `illegal`  out  1  unsupported opcode flag.
- `state_dbg`  out  4  current state encoding.

## Operation
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, TRAP 10.
- FETCH
  - Outputs: `mem_req`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, add, `ResultSrc`=10.
  - When `mem_ready`=1: assert `IRWrite` and `PCWrite`, go to DECODE. Otherwise stay in FETCH with both enables 0.
- DECODE
  - Outputs: `ALUSrcA`=01, `ALUSrcB`=01, add. This precomputes the branch target.
  - Next state by `op`: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; any other → illegal path (see Configuration).
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, add. Go to MEMREAD if `op`=0000011, else MEMWRITE.
- MEMREAD: `mem_req`=1, `AdrSrc`=1. Go to MEMWB when `mem_ready`=1.
- MEMWB: `ResultSrc`=01, `RegWrite`=1, then FETCH.
- MEMWRITE: `mem_req`=1, `AdrSrc`=1. `MemWrite`=1 only in the cycle `mem_ready`=1, then FETCH.
- EXECR / EXECI: `ALUSrcA`=10; `ALUSrcB`=00 for R, 01 for I; ALU decode below. Then ALUWB.
- ALUWB: `ResultSrc`=00, `RegWrite`=1, then FETCH.
- BEQ: `ALUSrcA`=10, `ALUSrcB`=00, sub, `ResultSrc`=00, `PCWrite`=`Zero`. Then FETCH.
- ALU decode, valid in EXECR/EXECI only (add in all other states):
  - funct3 000: sub if R-type and `funct7b5`=1, else add.
  - 010 → slt; 110 → or; 111 → and; other funct3 → add.
- `ImmSrc` is combinational from `op` in every state: store → 01, branch → 10, all others → 00.
- Any enable not listed for a state is 0.

## Timing
- Moore outputs decoded from the state register. Exceptions are `PCWrite`, `IRWrite` and `MemWrite`, which are qualified same-cycle by `mem_ready` or `Zero`.
- Latency with zero wait states: lw 5 cycles, sw/R/I 4 cycles, beq 3 cycles. Each `mem_ready`=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- `mem_req` stays high until the `mem_ready` cycle. `mem_ready` is ignored while `mem_req`=0.
- Reset: while `rst`=1, all enables and `mem_req` are forced to 0 and `illegal`=0. At the first edge with `rst`=1, the state becomes FETCH (`state_dbg`=0).
- Reset mid-instruction (including during a stalled access) abandons the instruction with no partial write.

## Configuration
- `MULTICYCLE_CTRL_TRAP_EN` defined:
  - An unsupported opcode in DECODE → TRAP.
  - TRAP holds all enables at 0 with `illegal`=1, until `rst`.
- Undefined:
  - An unsupported opcode in DECODE returns to FETCH, making the instruction a NOP.
  - `illegal` pulses 1 for that DECODE cycle only.
  - TRAP is unreachable.

## Test plan
- lw (`op`=0000011), `mem_ready` always 1 → states 0,1,2,3,4,0. `RegWrite`=1 only in state 4, with `ResultSrc`=01.
- sw (`op`=0100011), `mem_ready` low for 2 cycles in MEMWRITE → `ImmSrc`=01, one `MemWrite` pulse, total 6 cycles.
- R-type sub (`funct3`=000, `funct7b5`=1), then addi with `funct7b5`=1 → `ALUControl`=001 for the R-type, 000 for the addi. Each takes 4 cycles.
- beq with `Zero`=1, then `Zero`=0 → `ImmSrc`=10 and 3 cycles each; `PCWrite` asserted in BEQ only when `Zero`=1.
- `op`=1111111:
  - With the macro: `state_dbg`=10 and `illegal`=1 held for 10 cycles, no enables.
  - Without the macro: back in FETCH after 2 cycles, `illegal` high for 1 cycle.
- Assert `rst` during MEMREAD with `mem_ready`=0 → no `RegWrite`, and `state_dbg`=0 on the next edge.
